// File: rtl/reg_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_stage
// Description : Register-read / issue stage between decode and execute.
//               - Drives the register file's two combinational read addresses
//                 straight from the decoded source indices.
//               - Selects each operand from writeback data (same-cycle
//                 bypass) or register file data; index 0 always reads zero.
//               - Captures operands and pass-through fields into a one-entry
//                 output register with a valid/ready handshake to execute.
//               - Tracks pending destination writes in a 32-bit scoreboard
//                 and stalls decode on RAW/WAW hazards until the matching
//                 writeback retires.
// Ports       : clk_i, reset_i         clock, synchronous active-high reset
//               dec_*_i / dec_ready_o  decode-side handshake and fields
//               rf_addr*_o / rf_data*_i register file read port
//               wb_en_i/wb_addr_i/wb_data_i writeback strobe and payload
//               ex_*_o / ex_ready_i    execute-side handshake and fields
// Revision    : 1.0 - initial release
// ============================================================================
module reg_read_stage #(
    parameter int CTRL_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    // decode side
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [4:0]        dec_rs1_i,
    input  logic [4:0]        dec_rs2_i,
    input  logic [4:0]        dec_rd_i,
    input  logic              dec_wen_i,
    input  logic [CTRL_W-1:0] dec_ctrl_i,
    // register file read port
    output logic [4:0]        rf_addr1_o,
    output logic [4:0]        rf_addr2_o,
    input  logic [63:0]       rf_data1_i,
    input  logic [63:0]       rf_data2_i,
    // writeback
    input  logic              wb_en_i,
    input  logic [4:0]        wb_addr_i,
    input  logic [63:0]       wb_data_i,
    // execute side
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [63:0]       ex_rs1_val_o,
    output logic [63:0]       ex_rs2_val_o,
    output logic [4:0]        ex_rd_o,
    output logic              ex_wen_o,
    output logic [CTRL_W-1:0] ex_ctrl_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]       sb_q,        sb_d;
    logic              ex_valid_q,  ex_valid_d;
    logic [63:0]       ex_rs1_q,    ex_rs1_d;
    logic [63:0]       ex_rs2_q,    ex_rs2_d;
    logic [4:0]        ex_rd_q,     ex_rd_d;
    logic              ex_wen_q,    ex_wen_d;
    logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic [31:0] w_clr;     // writeback retiring register r this cycle
    logic [31:0] w_busy;    // register r still has a pending write
    logic        w_hazard;
    logic        w_slot_free;
    logic        w_accept;
    logic [63:0] w_op1;
    logic [63:0] w_op2;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_clr
            if (gi == 0) begin : g_zero
                assign w_clr[gi] = 1'b0;
            end else begin : g_reg
                assign w_clr[gi] = wb_en_i && (wb_addr_i == 5'(gi));
            end
        end
    endgenerate

    // A register whose writeback is presented this cycle is no longer busy:
    // the value is available through the bypass, which gives same-cycle RAW
    // release and lets a WAW instruction re-claim the register immediately.
    assign w_busy = sb_q & ~w_clr;

    // Source checks are unconditional; decode zeroes unused source fields,
    // and index 0 can never be busy.
    assign w_hazard = w_busy[dec_rs1_i] | w_busy[dec_rs2_i]
                    | (dec_wen_i & w_busy[dec_rd_i]);

    assign w_slot_free = ~ex_valid_q | ex_ready_i;
    assign dec_ready_o = w_slot_free & ~w_hazard;
    assign w_accept    = dec_valid_i & dec_ready_o;

    // ------------------------------------------------------------------
    // Register file addressing and operand selection
    // ------------------------------------------------------------------
    assign rf_addr1_o = dec_rs1_i;
    assign rf_addr2_o = dec_rs2_i;

    function automatic logic [63:0] sel_operand(
        input logic [4:0]  src,
        input logic [63:0] rf_val,
        input logic        wb_en,
        input logic [4:0]  wb_addr,
        input logic [63:0] wb_data
    );
        logic [63:0] val;
        if (src == 5'd0) begin
            val = 64'd0;
        end else if (wb_en && (wb_addr == src)) begin
            val = wb_data;
        end else begin
            val = rf_val;
        end
        return val;
    endfunction

    assign w_op1 = sel_operand(dec_rs1_i, rf_data1_i, wb_en_i, wb_addr_i, wb_data_i);
    assign w_op2 = sel_operand(dec_rs2_i, rf_data2_i, wb_en_i, wb_addr_i, wb_data_i);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        ex_wen_d   = ex_wen_q;
        ex_ctrl_d  = ex_ctrl_q;

        if (w_accept) begin
            ex_valid_d = 1'b1;
            ex_rs1_d   = w_op1;
            ex_rs2_d   = w_op2;
            ex_rd_d    = dec_rd_i;
            ex_wen_d   = dec_wen_i;
            ex_ctrl_d  = dec_ctrl_i;
        end else if (ex_valid_q && ex_ready_i) begin
            // Data fields hold after the handshake; only valid drops.
            ex_valid_d = 1'b0;
        end

        // Clear first, then set: a new claim wins over a same-cycle retire.
        sb_d = sb_q & ~w_clr;
        if (w_accept && dec_wen_i && (dec_rd_i != 5'd0)) begin
            sb_d[dec_rd_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sb_q       <= '0;
            ex_valid_q <= 1'b0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_wen_q   <= 1'b0;
            ex_ctrl_q  <= '0;
        end else begin
            sb_q       <= sb_d;
            ex_valid_q <= ex_valid_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            ex_wen_q   <= ex_wen_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_rs1_val_o = ex_rs1_q;
    assign ex_rs2_val_o = ex_rs2_q;
    assign ex_rd_o      = ex_rd_q;
    assign ex_wen_o     = ex_wen_q;
    assign ex_ctrl_o    = ex_ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_read_stage
// Description : Directed testbench for reg_read_stage. A small register file
//               model feeds the read port; accepted instructions are queued
//               with their expected operands and compared against the output
//               register while it is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_read_stage;

    localparam int CTRL_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              dec_valid;
    logic              dec_ready;
    logic [4:0]        dec_rs1, dec_rs2, dec_rd;
    logic              dec_wen;
    logic [CTRL_W-1:0] dec_ctrl;
    logic [4:0]        rf_addr1, rf_addr2;
    logic [63:0]       rf_data1, rf_data2;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [63:0]       wb_data;
    logic              ex_valid;
    logic              ex_ready;
    logic [63:0]       ex_rs1_val, ex_rs2_val;
    logic [4:0]        ex_rd;
    logic              ex_wen;
    logic [CTRL_W-1:0] ex_ctrl;

    always #5 clk = ~clk;

    reg_read_stage #(.CTRL_W(CTRL_W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .dec_valid_i  (dec_valid),
        .dec_ready_o  (dec_ready),
        .dec_rs1_i    (dec_rs1),
        .dec_rs2_i    (dec_rs2),
        .dec_rd_i     (dec_rd),
        .dec_wen_i    (dec_wen),
        .dec_ctrl_i   (dec_ctrl),
        .rf_addr1_o   (rf_addr1),
        .rf_addr2_o   (rf_addr2),
        .rf_data1_i   (rf_data1),
        .rf_data2_i   (rf_data2),
        .wb_en_i      (wb_en),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .ex_valid_o   (ex_valid),
        .ex_ready_i   (ex_ready),
        .ex_rs1_val_o (ex_rs1_val),
        .ex_rs2_val_o (ex_rs2_val),
        .ex_rd_o      (ex_rd),
        .ex_wen_o     (ex_wen),
        .ex_ctrl_o    (ex_ctrl)
    );

    // Register file model: combinational read, x0 reads zero.
    logic [63:0] rf_mem [32];
    assign rf_data1 = (rf_addr1 == 5'd0) ? 64'd0 : rf_mem[rf_addr1];
    assign rf_data2 = (rf_addr2 == 5'd0) ? 64'd0 : rf_mem[rf_addr2];

    typedef struct packed {
        logic [63:0]       v1;
        logic [63:0]       v2;
        logic [4:0]        rd;
        logic              wen;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl_sb;
    logic        mdl_exv;
    int          ntests = 0;
    int          nfail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic mdl_busy(input logic [4:0] r);
        return mdl_sb[r] && !(wb_en && (wb_addr == r) && (r != 5'd0));
    endfunction

    function automatic logic [63:0] mdl_op(input logic [4:0] s);
        if (s == 5'd0)                 return 64'd0;
        if (wb_en && (wb_addr == s))   return wb_data;
        return rf_mem[s];
    endfunction

    // One clock cycle: drive inputs after the edge, check combinational
    // outputs and the held output register mid-cycle, update the model at
    // the edge, then check registered state just after it.
    task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic w, input logic [31:0] c,
                        input logic er, input logic we, input logic [4:0] wa,
                        input logic [63:0] wd);
        logic exp_ready;
        logic acc;
        exp_t e;
        dec_valid = v;  dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd;
        dec_wen   = w;  dec_ctrl = c; ex_ready = er;
        wb_en     = we; wb_addr = wa; wb_data = wd;
        #4;
        exp_ready = (!mdl_exv || er) && !(mdl_busy(r1) || mdl_busy(r2) || (w && mdl_busy(rd)));
        if (!reset) chk("dec_ready", 64'(dec_ready), 64'(exp_ready));
        chk("rf_addr1", 64'(rf_addr1), 64'(r1));
        chk("rf_addr2", 64'(rf_addr2), 64'(r2));
        if (mdl_exv) begin
            ntests++;
            assert (q.size() > 0) else begin
                nfail++;
                $error("FAIL ex_queue: observed valid with %0d entries expected >0", q.size());
            end
            if (q.size() > 0) begin
                e = q[0];
                chk("ex_rs1_val", ex_rs1_val, e.v1);
                chk("ex_rs2_val", ex_rs2_val, e.v2);
                chk("ex_rd",      64'(ex_rd),   64'(e.rd));
                chk("ex_wen",     64'(ex_wen),  64'(e.wen));
                chk("ex_ctrl",    64'(ex_ctrl), 64'(e.ctrl));
                if (er) void'(q.pop_front());
            end
        end
        acc = !reset && v && exp_ready;
        if (acc) begin
            e.v1 = mdl_op(r1); e.v2 = mdl_op(r2);
            e.rd = rd; e.wen = w; e.ctrl = c;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            mdl_exv = 1'b0;
            mdl_sb  = '0;
            q.delete();
        end else begin
            if (we && wa != 5'd0) begin
                rf_mem[wa] = wd;
                mdl_sb[wa] = 1'b0;
            end
            if (acc && w && rd != 5'd0) mdl_sb[rd] = 1'b1;
            if (acc)              mdl_exv = 1'b1;
            else if (mdl_exv && er) mdl_exv = 1'b0;
        end
        chk("ex_valid", 64'(ex_valid), 64'(mdl_exv));
        chk("scoreboard", 64'(dut.sb_q), 64'(mdl_sb));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 64'd0 : (64'h1111_0000_0000_0000 | 64'(i * 16'h0101));
        mdl_sb = '0; mdl_exv = 1'b0;
        reset = 1'b1;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_wen = 0; dec_ctrl = 0;
        ex_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        @(posedge clk); #1;

        // Reset with garbage on the decode and writeback ports.
        step(1, 5'd3, 5'd4, 5'd9, 1, 32'hDEAD_0000, 1, 1, 5'd9, 64'h5);
        step(0, 5'd0, 5'd0, 5'd0, 0, 32'h0, 0, 0, 5'd0, 64'h0);
        reset = 1'b0;
        chk("rst_ex_rs1", ex_rs1_val, 64'd0);
        chk("rst_ex_rs2", ex_rs2_val, 64'd0);
        chk("rst_ex_rd",  64'(ex_rd),   64'd0);
        chk("rst_ex_wen", 64'(ex_wen),  64'd0);
        chk("rst_ex_ctrl",64'(ex_ctrl), 64'd0);

        // x1 <- op(x0, x0), then an independent instruction.
        step(1, 5'd0, 5'd0, 5'd1, 1, 32'hAAAA_0001, 1, 0, 5'd0, 64'h0);
        step(1, 5'd2, 5'd3, 5'd5, 1, 32'hAAAA_0002, 1, 0, 5'd0, 64'h0);

        // RAW on x5: stall, then release with same-cycle bypass.
        step(1, 5'd5, 5'd0, 5'd6, 0, 32'hAAAA_0003, 1, 0, 5'd0, 64'h0);
        step(1, 5'd5, 5'd0, 5'd6, 0, 32'hAAAA_0003, 1, 0, 5'd0, 64'h0);
        step(1, 5'd5, 5'd0, 5'd6, 0, 32'hAAAA_0003, 1, 1, 5'd5, 64'hDEAD_BEEF);

        // Execute back-pressure: output held for 3 cycles, then drains.
        step(1, 5'd2, 5'd4, 5'd8, 1, 32'hAAAA_0004, 0, 0, 5'd0, 64'h0);
        step(1, 5'd2, 5'd4, 5'd8, 1, 32'hAAAA_0004, 0, 0, 5'd0, 64'h0);
        step(1, 5'd2, 5'd4, 5'd8, 1, 32'hAAAA_0004, 0, 0, 5'd0, 64'h0);
        step(1, 5'd2, 5'd4, 5'd8, 1, 32'hAAAA_0004, 1, 0, 5'd0, 64'h0);

        // WAW on x7: claim, stall, then retire and re-claim in one cycle.
        step(1, 5'd0, 5'd0, 5'd7, 1, 32'hAAAA_0005, 1, 0, 5'd0, 64'h0);
        step(1, 5'd0, 5'd0, 5'd7, 1, 32'hAAAA_0006, 1, 0, 5'd0, 64'h0);
        step(1, 5'd0, 5'd0, 5'd7, 1, 32'hAAAA_0006, 1, 1, 5'd7, 64'h77);
        chk("waw_sb7", 64'(dut.sb_q[7]), 64'd1);

        // Writeback to x0 never bypasses; rd=0 never claims.
        step(1, 5'd0, 5'd0, 5'd0, 1, 32'hAAAA_0007, 1, 1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1, 5'd0, 5'd0, 5'd0, 1, 32'hAAAA_0008, 1, 0, 5'd0, 64'h0);

        // Writeback to an idle register still bypasses on both sources.
        step(1, 5'd9, 5'd9, 5'd10, 1, 32'hAAAA_0009, 1, 1, 5'd9, 64'h0123_4567_89AB_CDEF);

        // Fill output under back-pressure, then reset with a held instruction.
        step(1, 5'd2, 5'd3, 5'd4, 1, 32'hAAAA_000A, 1, 0, 5'd0, 64'h0);
        step(0, 5'd0, 5'd0, 5'd0, 0, 32'h0,        0, 0, 5'd0, 64'h0);
        reset = 1'b1;
        step(1, 5'd2, 5'd3, 5'd11, 1, 32'hBBBB_0000, 0, 1, 5'd1, 64'h9);
        reset = 1'b0;
        step(1, 5'd4, 5'd7, 5'd4, 1, 32'hAAAA_000B, 1, 0, 5'd0, 64'h0);

        // Drain.
        step(0, 5'd0, 5'd0, 5'd0, 0, 32'h0, 1, 0, 5'd0, 64'h0);
        step(0, 5'd0, 5'd0, 5'd0, 0, 32'h0, 1, 0, 5'd0, 64'h0);
        chk("drain_queue", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_read_stage.md
# reg_read_stage

Register-read / issue stage sitting directly upstream of the 32x64 register file and downstream of decode. Drives the register file's two combinational read addresses, captures operands into a one-entry pipeline register for execute, and bypasses same-cycle writeback data. A 32-bit scoreboard of pending destination writes stalls decode on RAW and WAW hazards until the matching writeback retires.

## Interface
- CTRL_W, 32, width of opaque decoded control bundle carried to execute
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dec_valid  in  1  decode presents an instruction
- dec_ready  out  1  stage accepts instruction this cycle
- dec_rs1, dec_rs2  in  5  source register indices
- dec_rd  in  5  destination index
- dec_wen  in  1  instruction writes dec_rd
- dec_ctrl  in  CTRL_W  control bundle, passed through
- rf_addr1, rf_addr2  out  5  register file read addresses
- rf_data1, rf_data2  in  64  register file read data (combinational, x0 reads 0)
- wb_en  in  1  writeback strobe (same signal that drives the register file write port)
- wb_addr  in  5  writeback index
- wb_data  in  64  writeback data
- ex_valid  out  1  operands valid to execute
- ex_ready  in  1  execute accepts
- ex_rs1_val, ex_rs2_val  out  64  captured operands
- ex_rd  out  5, ex_wen  out  1, ex_ctrl  out  CTRL_W  passed-through fields

## Operation
- rf_addr1 = dec_rs1, rf_addr2 = dec_rs2, always, independent of valid.
- Operand select per source s: if s != 0 and wb_en and wb_addr == s, use wb_data (bypass); else use rf_data. s == 0 always yields 0, never bypassed.
- Scoreboard sb[31:0]; sb[0] hard-wired 0.
- clr(r) = wb_en and wb_addr == r and r != 0.
- busy(r) = sb[r] and not clr(r).
- hazard = busy(dec_rs1) or busy(dec_rs2) or (dec_wen and busy(dec_rd)). Source checks apply even if the instruction does not use the field; decode drives unused fields to 0.
- slot_free = not ex_valid or ex_ready.
- dec_ready = slot_free and not hazard. Depends on dec_rs*/dec_rd but not on dec_valid.
- accept = dec_valid and dec_ready: output register loads operands/rd/wen/ctrl; ex_valid <= 1.
- Else if ex_valid and ex_ready: ex_valid <= 0; data fields hold.
- Scoreboard update per edge: first clear sb[wb_addr] if clr. Then, if accept and dec_wen and dec_rd != 0, set sb[dec_rd]. Set wins over a same-cycle clear of the same index.
- wb_en to a non-busy register or to x0: scoreboard no-op; bypass still applies for non-zero index.
- No flush; pipeline drains via writeback only.

## Timing
- Reset (sync, active-high): ex_valid=0, sb=0, ex_rs1_val/ex_rs2_val/ex_rd/ex_wen/ex_ctrl=0. An instruction held at reset is dropped. A reset cycle ignores dec_valid and wb_en.
- Latency: accepted at edge N, visible on ex_* from N onward (1 cycle). Throughput 1/cycle when no hazard and ex_ready=1.
- ex_* fields stable while ex_valid=1 and ex_ready=0.
- dec_ready combinational from sb, wb_*, ex_valid, ex_ready; no combinational path from dec_valid.
- RAW release: a dependent instruction issues in the same cycle wb_en presents its source, using the bypassed wb_data.

## Test plan
- Reset, then dec x1<-op(rs1=0,rs2=0), ex_ready=1 -> dec_ready=1; next cycle ex_valid=1, ex_rs1_val=0, ex_rd=1, sb[1]=1.
- With sb[5]=1, present rs1=5 -> dec_ready=0 until a cycle with wb_en=1, wb_addr=5, wb_data=64'hDEAD_BEEF. In that cycle the instruction is accepted and ex_rs1_val=64'hDEAD_BEEF next cycle; sb[5]=0.
- ex_ready=0 with ex_valid=1 -> dec_ready=0, ex_* unchanged for 3 cycles; raise ex_ready -> queued instruction loads the following cycle.
- WAW: sb[7]=1, dec rd=7 wen=1 -> stall. The same cycle wb_addr=7 clears and accepts -> sb[7] remains 1 (set wins).
- wb_en=1, wb_addr=0, wb_data=64'hFFFF…, dec rs1=0 -> ex_rs1_val=0. Dec rd=0 wen=1 never sets sb, and a following rs=0 is never stalled.
- Reset asserted with ex_valid=1 and sb=32'h0000_00F0 -> next cycle ex_valid=0, sb=0, dec_ready=1.
